// File: rtl/mix_columns_pipe_if.sv
// mix_columns_pipe_if: block stream bus for the MixColumns engine.
// Carries the input handshake/state and the output handshake/state/frame tag.
// The slave modport is the engine's view; the master modport is the view of the
// surrounding datapath that feeds and drains it.
interface mix_columns_pipe_if #(
    parameter int unsigned CNT_W = 14
) ();
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic             in_inv;
    logic             in_bypass;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic             out_last;
    logic [CNT_W-1:0] blk_cnt;

    modport slave (
        input  in_valid, in_data, in_inv, in_bypass, out_ready,
        output in_ready, out_valid, out_data, out_last, blk_cnt
    );

    modport master (
        output in_valid, in_data, in_inv, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, out_last, blk_cnt
    );
endinterface

// File: rtl/mix_columns_pipe.sv
// mix_columns_pipe: streaming AES MixColumns engine.
// One 128-bit state per cycle is transformed combinationally (forward, inverse or
// bypass, chosen per block) into stage 1, then delayed through PIPE_STAGES-1 more
// register stages. Output blocks carry a frame index that wraps at FRAME_BLOCKS.
// Optional feature macro: MIXCOL_INV_EN builds the InvMixColumns datapath; without
// it in_inv is ignored and such blocks receive the forward transform.
module mix_columns_pipe #(
    parameter int unsigned PIPE_STAGES  = 2,
    parameter int unsigned FRAME_BLOCKS = 16384,
    parameter int unsigned CNT_W        = 14
) (
    input logic               clk,
    input logic               rst,
    mix_columns_pipe_if.slave bus
);
    localparam int unsigned      LAST_STAGE = PIPE_STAGES - 1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_BLOCKS - 1);

    // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns on one column, row 0 in the top byte.
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIXCOL_INV_EN
    // InvMixColumns on one column; 9/b/d/e multiples built from chained xtime.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`else
    // Inverse mode is not built; the select input is deliberately left unused.
    logic unused_inv;
    assign unused_inv = bus.in_inv;
`endif

    logic [127:0]     xform;
    logic [127:0]     data_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] adv;
    logic             stage_room;
    logic [CNT_W-1:0] blk_cnt_q;

    // Per-block transform of the incoming state; bypass wins over inverse.
    always_comb begin
        xform = bus.in_data;
        if (!bus.in_bypass) begin
            for (int c = 0; c < 4; c++) begin
`ifdef MIXCOL_INV_EN
                xform[127-32*c -: 32] = bus.in_inv ? mix_inv(bus.in_data[127-32*c -: 32])
                                                   : mix_fwd(bus.in_data[127-32*c -: 32]);
`else
                xform[127-32*c -: 32] = mix_fwd(bus.in_data[127-32*c -: 32]);
`endif
            end
        end
    end

    // Ready chain from the output back to stage 1: a stage advances when it holds a
    // block and its successor is empty or advancing itself.
    always_comb begin
        logic room;
        room = bus.out_ready;
        adv  = '0;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            adv[k] = valid_q[k] & room;
            room   = ~valid_q[k] | room;
        end
        stage_room = room;
    end

    assign bus.in_ready  = rst & stage_room;
    assign bus.out_valid = valid_q[LAST_STAGE];
    assign bus.out_data  = data_q[LAST_STAGE];
    assign bus.out_last  = valid_q[LAST_STAGE] & (blk_cnt_q == LAST_IDX);
    assign bus.blk_cnt   = blk_cnt_q;

    // Pipeline registers; data only moves with a valid block so a stalled output holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (stage_room) begin
                valid_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    data_q[0] <= xform;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (!valid_q[k] || adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

    // Frame index of the block on the output; steps on each output transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt_q <= '0;
        end else if (adv[LAST_STAGE]) begin
            blk_cnt_q <= (blk_cnt_q == LAST_IDX) ? '0 : blk_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mix_columns_pipe.sv
// tb_mix_columns_pipe: directed, table-driven bench for mix_columns_pipe.
// A second instance with FRAME_BLOCKS=4 shares the input stream and output ready
// of the main instance, so its frame tagging can be checked on the same traffic.
module tb_mix_columns_pipe;
    localparam int PIPE = 2;
    localparam int NV   = 8;
    localparam int TMO  = 500;

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic rnd_en = 1'b0;
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;
    vec_t tbl [NV];

    logic [127:0] oq    [$];
    int           ocyc  [$];
    int           acyc  [$];
    logic [13:0]  ocnt  [$];
    logic         olast [$];
    logic [1:0]   fcnt  [$];
    logic         flast [$];

    mix_columns_pipe_if #(.CNT_W(14)) bus ();
    mix_columns_pipe_if #(.CNT_W(2))  fbus ();

    mix_columns_pipe #(.PIPE_STAGES(PIPE), .FRAME_BLOCKS(16384), .CNT_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mix_columns_pipe #(.PIPE_STAGES(PIPE), .FRAME_BLOCKS(4), .CNT_W(2)) dut_frame (
        .clk (clk),
        .rst (rst),
        .bus (fbus)
    );

    assign fbus.in_valid  = bus.in_valid;
    assign fbus.in_data   = bus.in_data;
    assign fbus.in_inv    = bus.in_inv;
    assign fbus.in_bypass = bus.in_bypass;
    assign fbus.out_ready = bus.out_ready;

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        oq.delete(); ocyc.delete(); acyc.delete(); ocnt.delete();
        olast.delete(); fcnt.delete(); flast.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 just after the block was taken.
    task automatic send(input vec_t v);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = v.din;
        bus.in_inv    = v.inv;
        bus.in_bypass = v.byp;
        @(negedge clk);
        while (!bus.in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no in_ready within %0d cycles", TMO);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input string name);
        int k = 0;
        while (oq.size() < n && k < TMO) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_count"}, 128'(oq.size()), 128'(n));
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk({name, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        chk({name, "_out_last"}, 128'(bus.out_last), 128'(0));
        chk({name, "_out_data"}, bus.out_data, 128'(0));
        chk({name, "_blk_cnt"}, 128'(bus.blk_cnt), 128'(0));
        chk({name, "_frame_blk_cnt"}, 128'(fbus.blk_cnt), 128'(0));
        chk({name, "_in_ready"}, 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk({name, "_ready_after_release"}, 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        clear_q();
    endtask

    // Output monitor: records transfers, checks the ready model and stall stability.
    int           occ     = 0;
    logic         stall_q = 1'b0;
    logic [127:0] prev_data;
    logic [13:0]  prev_cnt;
    logic         prev_last;
    always @(negedge clk) begin
        if (!rst) begin
            occ     = 0;
            stall_q = 1'b0;
            chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        end else begin
            chk("in_ready_model", 128'(bus.in_ready), 128'(!(occ == PIPE && !bus.out_ready)));
            if (stall_q) begin
                chk("stall_valid", 128'(bus.out_valid), 128'(1));
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_cnt", 128'(bus.blk_cnt), 128'(prev_cnt));
                chk("stall_last", 128'(bus.out_last), 128'(prev_last));
            end
            if (bus.in_valid && bus.in_ready) begin
                acyc.push_back(cyc);
                occ++;
            end
            if (bus.out_valid && bus.out_ready) begin
                oq.push_back(bus.out_data);
                ocyc.push_back(cyc);
                ocnt.push_back(bus.blk_cnt);
                olast.push_back(bus.out_last);
                fcnt.push_back(fbus.blk_cnt);
                flast.push_back(fbus.out_last);
                occ--;
            end
            stall_q   = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_cnt  = bus.blk_cnt;
            prev_last = bus.out_last;
        end
    end

    // Random output backpressure when enabled.
    initial forever begin
        @(posedge clk);
        #2;
        if (rnd_en) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] fips_in, fips_out, in2, out2, rnd, mid;
        vec_t         v;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_inv    = 1'b0;
        bus.in_bypass = 1'b0;
        bus.out_ready = 1'b0;

        fips_in  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
        fips_out = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
        in2      = 128'h2d26314c_c6c6c6c6_01010101_d4d4d4d5;
        out2     = 128'h4d7ebdf8_c6c6c6c6_01010101_d5d5d7d6;
        tbl[0] = '{fips_in, 1'b0, 1'b0, fips_out};
        tbl[1] = '{128'h01234567_89abcdef_fedcba98_76543210, 1'b1, 1'b1,
                   128'h01234567_89abcdef_fedcba98_76543210};
`ifdef MIXCOL_INV_EN
        tbl[2] = '{fips_out, 1'b1, 1'b0, fips_in};
        tbl[5] = '{out2, 1'b1, 1'b0, in2};
`else
        tbl[2] = '{fips_in, 1'b1, 1'b0, fips_out};
        tbl[5] = '{in2, 1'b1, 1'b0, out2};
`endif
        tbl[3] = '{in2, 1'b0, 1'b0, out2};
        tbl[4] = '{fips_in, 1'b0, 1'b1, fips_in};
        tbl[6] = '{128'hf20a225c_db135345_d4d4d4d5_2d26314c, 1'b0, 1'b0,
                   128'h9fdc589d_8e4da1bc_d5d5d7d6_4d7ebdf8};
        tbl[7] = '{{128{1'b1}}, 1'b0, 1'b1, {128{1'b1}}};

        // Power-on reset.
        #1 rst = 1'b0;
        #3;
        chk("por_out_valid", 128'(bus.out_valid), 128'(0));
        chk("por_out_last", 128'(bus.out_last), 128'(0));
        chk("por_out_data", bus.out_data, 128'(0));
        chk("por_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        chk("por_in_ready", 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("por_ready_after_release", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Vector table streamed back to back with mixed modes.
        clear_q();
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) send(tbl[i]);
        wait_outs(NV, "vec");
        for (int i = 0; i < NV && i < oq.size(); i++) begin
            chk($sformatf("vec%0d_data", i), oq[i], tbl[i].exp);
            chk($sformatf("vec%0d_out_gap", i), 128'(ocyc[i] - ocyc[0]), 128'(i));
        end
        for (int i = 0; i < NV && i < acyc.size(); i++)
            chk($sformatf("vec%0d_acc_gap", i), 128'(acyc[i] - acyc[0]), 128'(i));
        if (oq.size() > 0 && acyc.size() > 0)
            chk("vec_latency", 128'(ocyc[0] - acyc[0]), 128'(PIPE));

`ifdef MIXCOL_INV_EN
        // Random block forward then inverse must return the original.
        rnd = {$urandom, $urandom, $urandom, $urandom};
        clear_q();
        v = '{rnd, 1'b0, 1'b0, '0};
        send(v);
        wait_outs(1, "rt_fwd");
        mid = (oq.size() > 0) ? oq[0] : '0;
        clear_q();
        v = '{mid, 1'b1, 1'b0, '0};
        send(v);
        wait_outs(1, "rt_inv");
        if (oq.size() > 0) chk("roundtrip", oq[0], rnd);
`else
        rnd = '0;
        mid = '0;
`endif

        // Full pipeline: input stalls, output holds, then simultaneous accept/output.
        clear_q();
        bus.out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[3]);
        bus.in_valid  = 1'b1;
        bus.in_data   = tbl[6].din;
        bus.in_inv    = tbl[6].inv;
        bus.in_bypass = tbl[6].byp;
        #1 chk("full_in_ready", 128'(bus.in_ready), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold_ready", 128'(bus.in_ready), 128'(0));
        chk("full_hold_data", bus.out_data, tbl[0].exp);
        chk("full_hold_valid", 128'(bus.out_valid), 128'(1));
        bus.out_ready = 1'b1;
        #1 chk("simul_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_outs(3, "full");
        if (oq.size() == 3) begin
            chk("full_order0", oq[0], tbl[0].exp);
            chk("full_order1", oq[1], tbl[3].exp);
            chk("full_order2", oq[2], tbl[6].exp);
        end

        // Ten blocks under random backpressure.
        clear_q();
        rnd_en = 1'b1;
        for (int i = 0; i < 10; i++) send(tbl[i % NV]);
        wait_outs(10, "bp");
        rnd_en = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && i < oq.size(); i++)
            chk($sformatf("bp%0d_data", i), oq[i], tbl[i % NV].exp);

        // Frame wrap on the FRAME_BLOCKS=4 instance.
        do_reset("pre_frame");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(tbl[i % NV]);
        wait_outs(9, "frame");
        for (int i = 0; i < 9 && i < oq.size(); i++) begin
            chk($sformatf("frame%0d_cnt", i), 128'(fcnt[i]), 128'(i % 4));
            chk($sformatf("frame%0d_last", i), 128'(flast[i]), 128'(i % 4 == 3));
            chk($sformatf("main%0d_cnt", i), 128'(ocnt[i]), 128'(i));
            chk($sformatf("main%0d_last", i), 128'(olast[i]), 128'(0));
        end

        // Reset with two blocks in flight and blk_cnt at 5.
        do_reset("pre_mid");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(tbl[i]);
        wait_outs(5, "mid_fill");
        bus.out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[2]);
        chk("mid_cnt_before", 128'(bus.blk_cnt), 128'(5));
        chk("mid_valid_before", 128'(bus.out_valid), 128'(1));
        do_reset("mid_rst");
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("mid_no_stale", 128'(oq.size()), 128'(0));
        send(tbl[3]);
        wait_outs(1, "mid_after");
        if (oq.size() > 0) begin
            chk("mid_first_cnt", 128'(ocnt[0]), 128'(0));
            chk("mid_first_data", oq[0], tbl[3].exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mix_columns_pipe.md
# mix_columns_pipe

Parametrised, synthesizable streaming MixColumns engine for the AES datapath. It accepts one 128-bit AES state per cycle over a valid/ready handshake and applies forward MixColumns, InvMixColumns or bypass (final round) per block. The result passes through a configurable register pipeline, and each output block is tagged with a frame position. It sits between ShiftRows and AddRoundKey in the streaming image-encryption path, where each frame is a 512x512 8-bit image of 16384 blocks.

## Interface
- PIPE_STAGES, 2, number of register stages from accept to output; legal range 1..3.
- FRAME_BLOCKS, 16384, number of blocks per frame; controls `out_last` and counter wrap; must be ≥1.
- CNT_W, 14, width of `blk_cnt`; must satisfy 2^CNT_W ≥ FRAME_BLOCKS.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low (asserted when 0).
- in_valid  in  1  input block present.
- in_ready  out  1  block accepted when in_valid && in_ready at the clk edge.
- in_data  in  128  state; byte i = in_data[127-8i -: 8]; column c = bytes 4c..4c+3 (rows 0..3).
- in_inv  in  1  1 = InvMixColumns; sampled with the block.
- in_bypass  in  1  1 = pass the block unchanged; takes priority over in_inv.
- out_valid  out  1  output block present.
- out_ready  in  1  downstream accepts.
- out_data  out  128  transformed state, same byte layout as in_data.
- out_last  out  1  high with out_valid on the last block of a frame.
- blk_cnt  out  CNT_W  index within the frame of the block currently on out_data.

## Operation
- **Forward transform**, per column [a0..a3] over GF(2^8), poly 0x11B:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = (x<<1)^(x[7]?0x1B:0), truncated to 8 bits.
- **Inverse transform**: matrix rows [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e], built from chained xtime.
- **Pipeline structure**:
  - The transform is combinational from in_data into stage 1.
  - Stages 2..PIPE_STAGES are delay registers, each holding data plus a valid bit.
- **Flow control**:
  - Stage k advances when its successor is empty or advancing.
  - Last-stage advance = out_valid && out_ready.
  - in_ready = !valid[1] || advance[1] (combinational from out_ready; no skid buffer).
- **Frame counter**:
  - blk_cnt increments on each output transfer (out_valid && out_ready).
  - When blk_cnt = FRAME_BLOCKS-1, a transfer wraps it to 0.
  - out_last = out_valid && (blk_cnt == FRAME_BLOCKS-1).
  - FRAME_BLOCKS=1 gives out_last on every block.
- **Per-block mode**: in_inv and in_bypass are sampled per block, so modes may change block to block with no bubble.
- **Ordering**: the block never reorders, drops or duplicates blocks.

## Timing
- **Reset (rst=0)**, asynchronous; all valid bits clear:
  - out_valid=0, out_last=0, out_data=0, blk_cnt=0.
  - in_ready=0 while rst=0.
  - in_ready=1 in the first cycle after release.
- **Reset mid-frame**: in-flight blocks are discarded and blk_cnt returns to 0. The next accepted block is frame index 0.
- **Latency**: a block accepted at edge t shows out_valid=1 after edge t+PIPE_STAGES-1 (registered output), provided out_ready was held 1.
- **Throughput**: 1 block/cycle sustained while out_ready=1.
- **Backpressure**:
  - While out_valid && !out_ready, out_data, out_last and blk_cnt hold stable.
  - The pipeline fills; in_ready drops once all PIPE_STAGES stages are full.
  - At most PIPE_STAGES blocks are in flight.
- **Simultaneous accept and output on a full pipeline**: legal. in_ready=1 in that cycle because of the combinational ready chain.
- **Handshake rules**:
  - in_data, in_inv and in_bypass must be held stable while in_valid && !in_ready.
  - Once asserted, out_valid stays high until it is accepted.

## Configuration
- **MIXCOL_INV_EN defined**: the InvMixColumns datapath is built; in_inv selects it per block.
- **MIXCOL_INV_EN undefined**:
  - No inverse logic is built; in_inv is ignored and treated as 0.
  - A block with in_inv=1 and in_bypass=0 gets the forward transform.
  - Ports are unchanged.

## Test plan
- **Forward, FIPS-197 columns**: column db 13 53 45 -> 8e 4d a1 bc; f2 0a 22 5c -> 9f dc 58 9d; 01 01 01 01 -> 01 01 01 01; d4 d4 d4 d5 -> d5 d5 d7 d6, all with PIPE_STAGES=2. Required: out_valid rises 2 edges after accept.
- **Inverse (MIXCOL_INV_EN defined)**: 8e 4d a1 bc -> db 13 53 45. A random 128-bit block through forward then inverse returns the original. With the macro undefined, in_inv=1 gives the forward result.
- **Bypass and mode change**: alternate in_bypass=1 / in_inv=1 / in_inv=0 blocks back-to-back. Required: the bypass block is output bit-identical, there are no bubbles, and order is preserved.
- **Backpressure**: stream 10 blocks while randomly toggling out_ready.
  - in_ready=0 only when PIPE_STAGES stages are full.
  - out_data is stable while stalled.
  - All 10 blocks are received in order.
- **Frame wrap**: FRAME_BLOCKS=4, 9 blocks. Required: out_last on blocks 3 and 7; blk_cnt sequence 0,1,2,3,0,1,2,3,0.
- **Reset mid-operation**: pull rst=0 with 2 blocks in flight and blk_cnt=5. Required: out_valid=0 and blk_cnt=0 immediately (asynchronously). After release, the first output has blk_cnt=0 and no stale block appears.
